error_metrics_acc: RTL
======================

ERROR_METRICS_ACC -- requirements
Module: error_metrics_acc

Interface
REQ-001 SHALL have parameter W, default 8, width of exact and approximate operands.
REQ-002 SHALL have parameter LOG2_N, default 16, run length N = 2**LOG2_N samples.
REQ-003 SHALL have parameter FRAC, default 16, fraction bits of relative-error quotient.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  begin a new run (sampled in IDLE or DONE only).
REQ-007 in_valid  input  1  sample pair present.
REQ-008 in_ready  output  1  block accepts sample this cycle.
REQ-009 ref_val  input  W  exact result.
REQ-010 apx_val  input  W  approximate result.
REQ-011 err_count  output  LOG2_N+1  samples with ref_val != apx_val.
REQ-012 ed_sum  output  W+LOG2_N+1  sum of |ref_val - apx_val|.
REQ-013 ed_max  output  W  maximum |ref_val - apx_val|.
REQ-014 red_sum  output  W+FRAC+LOG2_N  sum of truncated ed/ref_val, unsigned Q(W+LOG2_N).FRAC.
REQ-015 done  output  1  run complete, results stable.

Function
REQ-016 SHALL implement FSM IDLE, RUN, DIV, DONE; reset state IDLE.
REQ-017 IDLE/DONE: start=1 SHALL clear all accumulators and the sample counter and enter RUN next cycle; done SHALL drop in the same transition.
REQ-018 in_ready SHALL be 1 only in RUN; in_valid outside RUN SHALL be ignored.
REQ-019 Transfer = in_valid & in_ready; per transfer: ed = |ref_val - apx_val| at W bits, err_count += (ed != 0), ed_sum += ed, ed_max = max(ed_max, ed), counter += 1, all visible the cycle after transfer.
REQ-020 start in RUN or DIV SHALL be ignored.
REQ-021 With RED_EN, a transfer with ed != 0 and ref_val != 0 SHALL enter DIV; in_ready low for exactly W+FRAC cycles; quotient (ed << FRAC) / ref_val truncated, added to red_sum on the DIV exit cycle; then RUN, or DONE if the run is complete.
REQ-022 ref_val == 0 or ed == 0 SHALL contribute nothing to red_sum and SHALL not enter DIV.
REQ-023 When the Nth sample completes (after any DIV), SHALL enter DONE; done held at 1 until next start; outputs frozen.
REQ-024 Accumulators SHALL never wrap: widths above hold worst case over N samples.

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE, clear the divider and every output to 0, including mid-RUN or mid-DIV; no partial result retained.
REQ-026 Reset release SHALL be used synchronously; first start accepted on the first rising edge after release.

Configuration
REQ-027 Macro ERROR_METRICS_RED_EN defined: divider, DIV state and red_sum accumulation present.
REQ-028 Macro undefined: no divider, DIV never entered, in_ready continuously 1 in RUN, red_sum tied to 0.

Structure
REQ-029 Package error_metrics_pkg SHALL hold the FSM state enum and default parameter constants (W, LOG2_N, FRAC).
REQ-030 Sub-module em_restoring_div SHALL implement the multi-cycle restoring divider (start/busy/quotient, one quotient bit per cycle, W+FRAC cycles).

Verification (W=8, LOG2_N=2, FRAC=8 unless stated)
REQ-031 Exact run: pairs (0,0),(1,1),(2,2),(3,3) -> err_count 0, ed_sum 0, ed_max 0, red_sum 0, done after 4th transfer.
REQ-032 Mixed run (no RED_EN): (10,12),(5,4),(200,190),(7,7) -> err_count 3, ed_sum 13, ed_max 10, red_sum 0.
REQ-033 RED_EN: (4,5),(2,1),(0,3),(8,8) -> red_sum 192 (64+128), ed_sum 5, err_count 3; in_ready low exactly 16 cycles after each of first two transfers, not after 3rd or 4th.
REQ-034 Reset mid-run: rst_n low after 2 transfers (also once mid-DIV) -> all outputs 0, in_ready 0, state IDLE; next start restarts cleanly.
REQ-035 Protocol: start pulsed during RUN and in_valid held during IDLE/DONE -> no effect on counters; new start in DONE clears results and drops done.

Source files
------------

// File: rtl/error_metrics_pkg.sv
// error_metrics_pkg: FSM state encoding and default sizing constants shared by
// the error-metrics accumulator and its divider.
package error_metrics_pkg;

  localparam int EM_W_DEFAULT      = 8;
  localparam int EM_LOG2_N_DEFAULT = 16;
  localparam int EM_FRAC_DEFAULT   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } em_state_e;

endpackage

// File: rtl/em_restoring_div.sv
// em_restoring_div: multi-cycle unsigned restoring divider computing
// (i_dividend << FRAC) / i_divisor, one quotient bit per cycle.
// The first bit is produced on the i_start edge itself, so the quotient is
// complete W+FRAC edges after start and o_busy is high for W+FRAC-1 cycles.
// The divisor must be non-zero.
module em_restoring_div #(
  parameter int W    = 8,
  parameter int FRAC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [W-1:0]      i_dividend,
  input  logic [W-1:0]      i_divisor,
  output logic              o_busy,
  output logic [W+FRAC-1:0] o_quot
);

  localparam int QW   = W + FRAC;
  localparam int CNTW = $clog2(QW);
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(QW - 1);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

  logic [QW-1:0]   r_q;
  logic [W-1:0]    r_rem;
  logic [W-1:0]    r_div;
  logic [CNTW-1:0] r_cnt;
  logic            r_busy;

  logic [QW-1:0]   w_q_src;
  logic [W-1:0]    w_rem_src;
  logic [W-1:0]    w_div_src;
  logic [W:0]      w_rem_sh;
  logic            w_ge;
  logic [W-1:0]    w_rem_sub;
  logic [W-1:0]    w_rem_nxt;
  logic [QW-1:0]   w_q_nxt;

  // Operand source: fresh operands on start, running state otherwise.
  always_comb begin
    w_q_src   = r_q;
    w_rem_src = r_rem;
    w_div_src = r_div;
    if (i_start) begin
      w_q_src   = {i_dividend, {FRAC{1'b0}}};
      w_rem_src = {W{1'b0}};
      w_div_src = i_divisor;
    end else begin
      w_q_src   = r_q;
      w_rem_src = r_rem;
      w_div_src = r_div;
    end
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // The remainder stays below the divisor, so W bits hold it after the step.
  assign w_rem_sh  = {w_rem_src, w_q_src[QW-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, w_div_src});
  assign w_rem_sub = w_rem_sh[W-1:0] - w_div_src;
  assign w_rem_nxt = w_ge ? w_rem_sub : w_rem_sh[W-1:0];
  assign w_q_nxt   = {w_q_src[QW-2:0], w_ge};

  // Divider state: load and first step on start, then one step per busy cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= {QW{1'b0}};
      r_rem  <= {W{1'b0}};
      r_div  <= {W{1'b0}};
      r_cnt  <= {CNTW{1'b0}};
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_q    <= w_q_nxt;
      r_rem  <= w_rem_nxt;
      r_div  <= i_divisor;
      r_cnt  <= CNT_LOAD;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_q    <= w_q_nxt;
      r_rem  <= w_rem_nxt;
      r_cnt  <= r_cnt - CNT_ONE;
      r_busy <= (r_cnt != CNT_ONE);
    end else begin
      r_busy <= 1'b0;
    end
  end

  assign o_busy = r_busy;
  assign o_quot = r_q;

endmodule

// File: rtl/error_metrics_acc.sv
// error_metrics_acc: accumulates error statistics between exact and
// approximate results over a run of N = 2**LOG2_N samples.
// Optional feature macro: ERROR_METRICS_RED_EN adds the relative-error
// divider, the DIV state and red_sum accumulation; without it red_sum is 0.
module error_metrics_acc
  import error_metrics_pkg::*;
#(
  parameter int W      = EM_W_DEFAULT,
  parameter int LOG2_N = EM_LOG2_N_DEFAULT,
  parameter int FRAC   = EM_FRAC_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             ref_val,
  input  logic [W-1:0]             apx_val,
  output logic [LOG2_N:0]          err_count,
  output logic [W+LOG2_N:0]        ed_sum,
  output logic [W-1:0]             ed_max,
  output logic [W+FRAC+LOG2_N-1:0] red_sum,
  output logic                     done
);

  localparam int CW = LOG2_N + 1;
  localparam int SW = W + LOG2_N + 1;
  localparam int RW = W + FRAC + LOG2_N;
  localparam logic [CW-1:0] N_L = {1'b1, {LOG2_N{1'b0}}};

  em_state_e     r_state;
  em_state_e     w_state_nxt;
  logic          r_in_ready;
  logic          r_done;
  logic          w_in_ready_nxt;
  logic          w_done_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_err;
  logic [SW-1:0] r_ed_sum;
  logic [W-1:0]  r_ed_max;

  logic          w_xfer;
  logic          w_clear;
  logic [W-1:0]  w_ed;
  logic          w_err;
  logic [CW-1:0] w_cnt_inc;
  logic          w_last;
  logic          w_need_div;
  logic          w_div_done;

  assign w_xfer    = in_valid & r_in_ready;
  assign w_clear   = start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
  assign w_ed      = (ref_val >= apx_val) ? (ref_val - apx_val) : (apx_val - ref_val);
  assign w_err     = |w_ed;
  assign w_cnt_inc = r_cnt + {{LOG2_N{1'b0}}, 1'b1};
  assign w_last    = (w_cnt_inc == N_L);

`ifdef ERROR_METRICS_RED_EN
  localparam int QW = W + FRAC;

  logic          w_div_start;
  logic          w_div_busy;
  logic [QW-1:0] w_div_quot;
  logic [RW-1:0] r_red_sum;

  // Division is only worth doing when there is an error and a usable divisor.
  assign w_need_div  = w_err & (|ref_val);
  assign w_div_start = w_xfer & w_need_div;
  assign w_div_done  = (r_state == ST_DIV) & ~w_div_busy;

  em_restoring_div #(
    .W    (W),
    .FRAC (FRAC)
  ) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_div_start),
    .i_dividend (w_ed),
    .i_divisor  (ref_val),
    .o_busy     (w_div_busy),
    .o_quot     (w_div_quot)
  );

  // Relative-error sum: cleared on start, quotient added as DIV exits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_red_sum <= {RW{1'b0}};
    end else if (w_clear) begin
      r_red_sum <= {RW{1'b0}};
    end else if (w_div_done) begin
      r_red_sum <= r_red_sum + {{LOG2_N{1'b0}}, w_div_quot};
    end else begin
      r_red_sum <= r_red_sum;
    end
  end

  assign red_sum = r_red_sum;
`else
  assign w_need_div = 1'b0;
  assign w_div_done = 1'b1;
  assign red_sum    = {RW{1'b0}};
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: start only honoured in IDLE/DONE, DIV after a divisible error.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_RUN: begin
        if (w_xfer && w_need_div) begin
          w_state_nxt = ST_DIV;
        end else if (w_xfer && w_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DIV: begin
        if (w_div_done) begin
          w_state_nxt = (r_cnt == N_L) ? ST_DONE : ST_RUN;
        end else begin
          w_state_nxt = ST_DIV;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so in_ready/done come from flops.
  always_comb begin
    w_in_ready_nxt = 1'b0;
    w_done_nxt     = 1'b0;
    if (w_state_nxt == ST_RUN) begin
      w_in_ready_nxt = 1'b1;
    end else if (w_state_nxt == ST_DONE) begin
      w_done_nxt = 1'b1;
    end else begin
      w_in_ready_nxt = 1'b0;
      w_done_nxt     = 1'b0;
    end
  end

  // Registered handshake and completion flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_in_ready <= w_in_ready_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // Sample counter and error accumulators: cleared on start, updated per transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= {CW{1'b0}};
      r_err    <= {CW{1'b0}};
      r_ed_sum <= {SW{1'b0}};
      r_ed_max <= {W{1'b0}};
    end else if (w_clear) begin
      r_cnt    <= {CW{1'b0}};
      r_err    <= {CW{1'b0}};
      r_ed_sum <= {SW{1'b0}};
      r_ed_max <= {W{1'b0}};
    end else if (w_xfer) begin
      r_cnt    <= w_cnt_inc;
      r_err    <= r_err + {{LOG2_N{1'b0}}, w_err};
      r_ed_sum <= r_ed_sum + {{(SW-W){1'b0}}, w_ed};
      r_ed_max <= (w_ed > r_ed_max) ? w_ed : r_ed_max;
    end else begin
      r_cnt    <= r_cnt;
      r_err    <= r_err;
      r_ed_sum <= r_ed_sum;
      r_ed_max <= r_ed_max;
    end
  end

  assign in_ready  = r_in_ready;
  assign done      = r_done;
  assign err_count = r_err;
  assign ed_sum    = r_ed_sum;
  assign ed_max    = r_ed_max;

endmodule
